ram_burst_ctrl: RTL and testbench

Initiator-side controller for the 4×8 register-file RAM. It accepts read or write burst requests on a valid/ready command port and streams write data in, or read data out, with valid/ready handshakes. It drives the RAM's address, data_in and write_en pins and captures its combinational data_out. The controller sits between the CPU datapath and the RAM so that multi-word transfers need no per-word sequencing upstream.

---
 rtl/ram_burst_ctrl.sv | 107 ++++++++++
 tb/tb_ram_burst_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_ctrl.sv
// Burst controller for the 4x8 register-file RAM: accepts read/write burst requests and
// streams words to or from the RAM with valid/ready handshakes on both data directions.
module ram_burst_ctrl #(
  parameter int WORDSIZE  = 8,
  parameter int ADDR_SIZE = 2
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [ADDR_SIZE-1:0] req_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [WORDSIZE-1:0]  wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [WORDSIZE-1:0]  rd_data,
  output logic                 rd_last,
  output logic                 busy,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORDSIZE-1:0]  ram_data_in,
  output logic                 ram_write_en,
  input  logic [WORDSIZE-1:0]  ram_data_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;

  logic [1:0]           state;
  logic [ADDR_SIZE-1:0] cur_addr;
  logic [ADDR_SIZE-1:0] beats_left;
  logic [WORDSIZE-1:0]  rd_data_p1;
  logic                 vld_p1;
  logic                 rd_last_p1;
  logic                 load;
  logic                 last_beat;

  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    return a + ADDR_SIZE'(1);
  endfunction

  assign req_ready    = (state == IDLE) && !vld_p1 && !clr;
  assign wr_ready     = (state == WRITE) && !clr;
  assign ram_write_en = (state == WRITE) && wr_valid && !clr;
  assign ram_addr     = cur_addr;
  assign ram_data_in  = wr_data;
  assign busy         = (state != IDLE);
  assign load         = (state == READ) && (!vld_p1 || rd_ready);
  assign last_beat    = (beats_left == '0);

  assign rd_valid = vld_p1;
  assign rd_data  = rd_data_p1;
  assign rd_last  = rd_last_p1;

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      cur_addr   <= '0;
      beats_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            cur_addr   <= req_addr;
            beats_left <= req_len;
            state      <= req_we ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_valid) begin
            cur_addr   <= next_addr(cur_addr);
            beats_left <= beats_left - ADDR_SIZE'(1);
            if (last_beat) state <= IDLE;
          end
        end
        READ: begin
          if (load) begin
            cur_addr   <= next_addr(cur_addr);
            beats_left <= beats_left - ADDR_SIZE'(1);
            if (last_beat) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // stage p1: registered read word, one cycle after ram_addr
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_p1     <= 1'b0;
      rd_last_p1 <= 1'b0;
      rd_data_p1 <= '0;
    end else if (load) begin
      vld_p1     <= 1'b1;
      rd_last_p1 <= last_beat;
      rd_data_p1 <= ram_data_out;
    end else if (vld_p1 && rd_ready) begin
      vld_p1     <= 1'b0;
      rd_last_p1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: table-driven bursts, hand-written corner sequences and
// randomized bursts checked by a word-level RAM/transfer scoreboard.
module tb_ram_burst_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       req_valid, req_ready, req_we;
  logic [1:0] req_addr, req_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready, rd_last;
  logic [7:0] rd_data;
  logic       busy;
  logic [1:0] ram_addr;
  logic [7:0] ram_data_in, ram_data_out;
  logic       ram_write_en;

  always #5 clk = ~clk;

  ram_burst_ctrl #(.WORDSIZE(8), .ADDR_SIZE(2)) dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_write_en(ram_write_en), .ram_data_out(ram_data_out)
  );

  // 4x8 register-file RAM with combinational read
  logic [7:0] mem [4];
  always @(posedge clk) if (ram_write_en) mem[ram_addr] <= ram_data_in;
  assign ram_data_out = mem[ram_addr];

  int tests = 0;
  int fails = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // word-level reference: expected RAM contents and expected transfers in order
  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
    bit         last;
  } beat_t;
  beat_t      wq[$];
  beat_t      rq[$];
  logic [7:0] ref_mem [4];
  bit         sb_en = 1'b0;

  always @(negedge clk) begin
    if (sb_en) begin
      if (ram_write_en) begin
        if (wq.size() == 0) chk("sb_unexpected_write", 1, 0);
        else begin
          beat_t b;
          b = wq.pop_front();
          chk("sb_waddr", ram_addr, b.a);
          chk("sb_wdata", ram_data_in, b.d);
        end
      end
      if (rd_valid && rd_ready) begin
        if (rq.size() == 0) chk("sb_unexpected_read", 1, 0);
        else begin
          beat_t b;
          b = rq.pop_front();
          chk("sb_rdata", rd_data, b.d);
          chk("sb_rlast", rd_last, b.last);
        end
      end
    end
  end

  typedef struct {
    bit              we;
    logic [1:0]      addr;
    logic [1:0]      len;
    logic [3:0][7:0] d;
  } vec_t;
  vec_t vt [4];

  logic [3:0][7:0] burst_d;
  logic [3:0][7:0] got_d;
  logic [3:0]      got_last;
  int              wen_cnt;
  int              done_cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 = no stalls, 1 = wr_valid toggling 1,0,1..., 2 = random stalls
  task automatic run_burst(input bit we, input logic [1:0] a, input logic [1:0] l, input int mode);
    int n, beats, cyc;
    req_valid = 1'b1; req_we = we; req_addr = a; req_len = l;
    #1;
    n = 0;
    while (!req_ready) begin
      if (n >= 50) begin
        chk("req_ready_timeout", 0, 1);
        req_valid = 1'b0;
        return;
      end
      tick(); #1; n++;
    end
    if (sb_en) begin
      for (int i = 0; i <= int'(l); i++) begin
        beat_t b;
        b.a = a + 2'(i);
        b.last = (i == int'(l));
        if (we) begin
          b.d = burst_d[i];
          ref_mem[b.a] = b.d;
          wq.push_back(b);
        end else begin
          b.d = ref_mem[b.a];
          rq.push_back(b);
        end
      end
    end
    tick();
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = 2'($urandom); req_len = 2'($urandom);
    beats = 0; cyc = 1; wen_cnt = 0;
    while (beats <= int'(l)) begin
      if (cyc > 80) begin
        chk("burst_timeout", 0, 1);
        break;
      end
      if (we) begin
        wr_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 1) : 1'($urandom);
        wr_data  = burst_d[beats];
        #1;
        if (ram_write_en) wen_cnt++;
        if (wr_valid && wr_ready) beats++;
      end else begin
        rd_ready = (mode == 0) ? 1'b1 : 1'($urandom);
        #1;
        if (rd_valid && rd_ready) begin
          got_d[beats]    = rd_data;
          got_last[beats] = rd_last;
          beats++;
        end
      end
      tick();
      cyc++;
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    #1;
    done_cyc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int   acc, second_at;
    logic [7:0] wq_d[$];
    logic       wq_l[$];

    clr = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

    tick(); #1;
    chk("clr_req_ready", req_ready, 0);
    chk("clr_wr_ready", wr_ready, 0);
    clr = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_write_en", ram_write_en, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_req_ready", req_ready, 1);

    vt[0] = '{we: 1'b1, addr: 2'd0, len: 2'd3, d: {8'h44, 8'h33, 8'h22, 8'h11}};
    vt[1] = '{we: 1'b0, addr: 2'd2, len: 2'd3, d: {8'h22, 8'h11, 8'h44, 8'h33}};
    vt[2] = '{we: 1'b0, addr: 2'd0, len: 2'd0, d: {8'h00, 8'h00, 8'h00, 8'h11}};
    vt[3] = '{we: 1'b0, addr: 2'd3, len: 2'd1, d: {8'h00, 8'h00, 8'h11, 8'h44}};

    for (int t = 0; t < 4; t++) begin
      burst_d = vt[t].d;
      run_burst(vt[t].we, vt[t].addr, vt[t].len, 0);
      if (vt[t].we) begin
        chk("tbl_wr_en_cycles", wen_cnt, int'(vt[t].len) + 1);
        chk("tbl_wr_done_cycle", done_cyc, int'(vt[t].len) + 2);
        for (int k = 0; k <= int'(vt[t].len); k++) begin
          logic [1:0] ad;
          ad = vt[t].addr + 2'(k);
          chk("tbl_ram_word", mem[ad], vt[t].d[k]);
        end
      end else begin
        chk("tbl_rd_done_cycle", done_cyc, int'(vt[t].len) + 3);
        for (int k = 0; k <= int'(vt[t].len); k++) begin
          chk("tbl_rd_data", got_d[k], vt[t].d[k]);
          chk("tbl_rd_last", got_last[k], k == int'(vt[t].len));
        end
      end
      chk("tbl_done_req_ready", req_ready, 1);
      chk("tbl_done_busy", busy, 0);
    end

    // read with consumer stall: addr 1, len 1
    req_valid = 1'b1; req_we = 1'b0; req_addr = 2'd1; req_len = 2'd1;
    #1;
    chk("stall_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0; rd_ready = 1'b0;
    #1;
    chk("stall_c1_rd_valid", rd_valid, 0);
    for (int c = 2; c <= 4; c++) begin
      tick(); #1;
      chk("stall_hold_valid", rd_valid, 1);
      chk("stall_hold_data", rd_data, 8'h22);
      chk("stall_hold_last", rd_last, 0);
    end
    tick();
    rd_ready = 1'b1;
    #1;
    chk("stall_c5_data", rd_data, 8'h22);
    tick(); #1;
    chk("stall_c6_valid", rd_valid, 1);
    chk("stall_c6_data", rd_data, 8'h33);
    chk("stall_c6_last", rd_last, 1);
    tick();
    rd_ready = 1'b0;
    #1;
    chk("stall_c7_valid", rd_valid, 0);
    chk("stall_c7_req_ready", req_ready, 1);

    // write with wr_valid toggling: addr 3, len 2
    burst_d = {8'h00, 8'hC3, 8'hB2, 8'hA1};
    run_burst(1'b1, 2'd3, 2'd2, 1);
    chk("tog_wr_en_cycles", wen_cnt, 3);
    chk("tog_done_cycle", done_cyc, 6);
    chk("tog_mem3", mem[3], 8'hA1);
    chk("tog_mem0", mem[0], 8'hB2);
    chk("tog_mem1", mem[1], 8'hC3);
    chk("tog_mem2_untouched", mem[2], 8'h33);

    // req_valid held high across a read burst
    req_valid = 1'b1; req_we = 1'b0; req_addr = 2'd0; req_len = 2'd1; rd_ready = 1'b1;
    #1;
    acc = 0; second_at = -1;
    for (int c = 0; c < 12; c++) begin
      if (req_valid && req_ready) begin
        acc++;
        if (acc == 2) second_at = c;
      end
      if (rd_valid && rd_ready) begin
        wq_d.push_back(rd_data);
        wq_l.push_back(rd_last);
      end
      tick();
      if (c == 0) begin req_addr = 2'd2; req_len = 2'd0; end
      if (acc == 2) req_valid = 1'b0;
      #1;
    end
    rd_ready = 1'b0;
    chk("hold_accepts", acc, 2);
    chk("hold_second_cycle", second_at, 4);
    chk("hold_words", wq_d.size(), 3);
    if (wq_d.size() == 3) begin
      chk("hold_w0", wq_d[0], 8'hB2);
      chk("hold_w1", wq_d[1], 8'hC3);
      chk("hold_w2", wq_d[2], 8'h33);
      chk("hold_l0", wq_l[0], 0);
      chk("hold_l1", wq_l[1], 1);
      chk("hold_l2", wq_l[2], 1);
    end

    // clr in cycle 2 of a 4-beat write
    req_valid = 1'b1; req_we = 1'b1; req_addr = 2'd0; req_len = 2'd3;
    #1;
    tick();
    req_valid = 1'b0; wr_valid = 1'b1; wr_data = 8'hD0;
    #1;
    chk("clrw_c1_write_en", ram_write_en, 1);
    tick();
    clr = 1'b1; wr_data = 8'hD1;
    #1;
    chk("clrw_c2_write_en", ram_write_en, 0);
    chk("clrw_c2_wr_ready", wr_ready, 0);
    chk("clrw_c2_req_ready", req_ready, 0);
    tick();
    clr = 1'b0; wr_data = 8'hD2;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 2'd1; req_len = 2'd0;
    #1;
    chk("clrw_busy", busy, 0);
    chk("clrw_rd_valid", rd_valid, 0);
    chk("clrw_rd_data", rd_data, 0);
    chk("clrw_rd_last", rd_last, 0);
    chk("clrw_wr_ready", wr_ready, 0);
    chk("clrw_write_en", ram_write_en, 0);
    chk("clrw_ram_addr", ram_addr, 0);
    chk("clrw_req_ready", req_ready, 1);
    chk("clrw_mem0", mem[0], 8'hD0);
    chk("clrw_mem1", mem[1], 8'hC3);
    tick();
    req_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b1;
    #1;
    tick(); #1;
    chk("clrw_rd_valid2", rd_valid, 1);
    chk("clrw_rd_data2", rd_data, 8'hC3);
    chk("clrw_rd_last2", rd_last, 1);
    tick();
    rd_ready = 1'b0;
    #1;

    // randomized bursts against the scoreboard
    sb_en = 1'b1;
    for (int k = 0; k < 4; k++) burst_d[k] = 8'($urandom);
    run_burst(1'b1, 2'd0, 2'd3, 0);
    for (int it = 0; it < 40; it++) begin
      bit we;
      we = 1'($urandom);
      for (int k = 0; k < 4; k++) burst_d[k] = 8'($urandom);
      run_burst(we, 2'($urandom), 2'($urandom),
                we ? int'($urandom_range(0, 2)) : (($urandom_range(0, 1) == 0) ? 0 : 2));
    end
    tick(); tick(); #1;
    sb_en = 1'b0;
    chk("sb_wq_empty", wq.size(), 0);
    chk("sb_rq_empty", rq.size(), 0);
    for (int k = 0; k < 4; k++) chk("sb_final_mem", mem[k], ref_mem[k]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
